dcache_sa: RTL and testbench

- Parametrised set-associative, write-back, write-allocate L1 data cache between the Load/Store Buffer and the memory controller.
- Successor to the direct-mapped data cache:
  - configurable ways, sets and line size
  - explicit FSM with valid/ready handshakes
  - round-robin replacement
  - MMIO bypass
  - misalignment error reporting
- Services one outstanding request at a time.

---
 rtl/dcache_pkg.sv | 30 +++
 rtl/dcache_lane_merge.sv | 43 ++++
 rtl/dcache_sa.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_dcache_sa.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// dcache_pkg : shared sizes, FSM states and address-field helper for dcache_sa
// Revision   : 1.0
// ============================================================================
package dcache_pkg;

  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic [1:0] IO_PREFIX_DEF = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOOKUP = 3'd1,
    ST_WBACK  = 3'd2,
    ST_REFILL = 3'd3,
    ST_IO     = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  // Address layout is {tag, set, offset}; the tag takes whatever is left.
  function automatic int tag_width(input int set_w, input int block_w);
    return 32 - set_w - block_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_lane_merge.sv
`default_nettype none
// ============================================================================
// dcache_lane_merge : byte-lane extract for loads, masked merge for stores
// Revision          : 1.0
// ============================================================================
module dcache_lane_merge
  import dcache_pkg::*;
#(
  parameter int BLOCK_WIDTH = 4
) (
  input  logic [(8<<BLOCK_WIDTH)-1:0] line_i,
  input  logic [BLOCK_WIDTH-1:0]      offset_i,
  input  logic [1:0]                  size_i,
  input  logic [31:0]                 wdata_i,
  output logic [31:0]                 rdata_o,
  output logic [(8<<BLOCK_WIDTH)-1:0] line_o
);

  localparam int LINE_W = 8 << BLOCK_WIDTH;

  logic [31:0]            size_mask;
  logic [BLOCK_WIDTH+2:0] shamt;
  logic [LINE_W-1:0]      mask_ext;
  logic [LINE_W-1:0]      data_ext;

  always_comb begin
    case (size_i)
      SIZE_BYTE: size_mask = 32'h0000_00FF;
      SIZE_HALF: size_mask = 32'h0000_FFFF;
      SIZE_WORD: size_mask = 32'hFFFF_FFFF;
      default:   size_mask = 32'h0000_0000;
    endcase
    shamt            = {offset_i, 3'b000};
    rdata_o          = 32'(line_i >> shamt) & size_mask;
    mask_ext         = '0;
    mask_ext[31:0]   = size_mask;
    data_ext         = '0;
    data_ext[31:0]   = wdata_i & size_mask;
    line_o           = (line_i & ~(mask_ext << shamt)) | (data_ext << shamt);
  end

endmodule
`default_nettype wire

// File: rtl/dcache_sa.sv
`default_nettype none
// ============================================================================
// dcache_sa : set-associative write-back L1 data cache with MMIO bypass.
//             Define DCACHE_STATS_EN for hit/miss/writeback counters.
// Revision  : 1.0
// ============================================================================
module dcache_sa
  import dcache_pkg::*;
#(
  parameter int         WAYS        = 2,
  parameter int         SET_WIDTH   = 6,
  parameter int         BLOCK_WIDTH = 4,
  parameter logic [1:0] IO_PREFIX   = IO_PREFIX_DEF
) (
  input  logic                        clkIn,
  input  logic                        resetIn,
  input  logic                        clearIn,
  input  logic                        reqValid,
  output logic                        reqReady,
  input  logic                        reqWrite,
  input  logic [1:0]                  reqSize,
  input  logic [31:0]                 reqAddr,
  input  logic [31:0]                 reqData,
  output logic                        respValid,
  output logic [31:0]                 respData,
  output logic                        respErr,
  output logic                        memReqValid,
  input  logic                        memReqReady,
  output logic                        memReqWrite,
  output logic [31-BLOCK_WIDTH:0]     memReqAddr,
  output logic [(8<<BLOCK_WIDTH)-1:0] memReqData,
  input  logic                        memRespValid,
  input  logic [(8<<BLOCK_WIDTH)-1:0] memRespData,
  output logic                        ioReqValid,
  output logic                        ioReqWrite,
  output logic [1:0]                  ioReqSize,
  output logic [31:0]                 ioReqAddr,
  output logic [31:0]                 ioReqData,
  input  logic                        ioRespValid,
  input  logic [31:0]                 ioRespData
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                 statHits,
  output logic [31:0]                 statMisses,
  output logic [31:0]                 statWbacks
`endif
);

  localparam int SETS   = 1 << SET_WIDTH;
  localparam int LINE_W = 8 << BLOCK_WIDTH;
  localparam int TAG_W  = tag_width(SET_WIDTH, BLOCK_WIDTH);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d, wdata_q, wdata_d, resp_data_q, resp_data_d;
  logic [1:0]         size_q, size_d;
  logic               write_q, write_d, replay_q, replay_d, drop_q, drop_d;
  logic               sent_q, sent_d, err_q, err_d;
  logic [WAY_W-1:0]   victim_q, victim_d;

  logic [TAG_W-1:0]   tag_q   [WAYS][SETS];
  logic [LINE_W-1:0]  data_q  [WAYS][SETS];
  logic [SETS-1:0]    valid_q [WAYS];
  logic [SETS-1:0]    dirty_q [WAYS];
  logic [WAY_W-1:0]   rr_q    [SETS];

  logic [SET_WIDTH-1:0] set_idx;
  logic [TAG_W-1:0]     tag_idx;
  logic                 hit, has_inv, misaligned, is_io;
  logic [WAY_W-1:0]     hit_way, inv_way, victim, rr_next;
  logic [31:0]          rdata;
  logic [LINE_W-1:0]    merged;
  logic                 do_merge, do_wb_done, do_install;

  assign set_idx    = addr_q[BLOCK_WIDTH +: SET_WIDTH];
  assign tag_idx    = addr_q[31 -: TAG_W];
  assign misaligned = ((size_q == SIZE_HALF) && addr_q[0]) ||
                      ((size_q == SIZE_WORD) && (addr_q[1:0] != 2'b00));
  assign is_io      = (addr_q[17:16] == IO_PREFIX);

  // Descending scan leaves the lowest matching index in hit_way/inv_way.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    has_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][set_idx] && (tag_q[w][set_idx] == tag_idx)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][set_idx]) begin
        has_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  assign victim  = has_inv ? inv_way : rr_q[set_idx];
  assign rr_next = (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + 1'b1;

  dcache_lane_merge #(.BLOCK_WIDTH(BLOCK_WIDTH)) u_lane_merge (
    .line_i   (data_q[hit_way][set_idx]),
    .offset_i (addr_q[BLOCK_WIDTH-1:0]),
    .size_i   (size_q),
    .wdata_i  (wdata_q),
    .rdata_o  (rdata),
    .line_o   (merged)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    write_d     = write_q;
    replay_d    = replay_q;
    drop_d      = drop_q;
    sent_d      = sent_q;
    err_d       = err_q;
    victim_d    = victim_q;
    resp_data_d = resp_data_q;
    reqReady    = 1'b0;
    respValid   = 1'b0;
    memReqValid = 1'b0;
    memReqWrite = 1'b0;
    ioReqValid  = 1'b0;
    do_merge    = 1'b0;
    do_wb_done  = 1'b0;
    do_install  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        reqReady = !clearIn;
        if (reqValid && !clearIn) begin
          addr_d   = reqAddr;
          wdata_d  = reqData;
          size_d   = reqSize;
          write_d  = reqWrite;
          replay_d = 1'b0;
          drop_d   = 1'b0;
          err_d    = 1'b0;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (clearIn) begin
          state_d = ST_IDLE;
        end else if (misaligned) begin
          err_d       = 1'b1;
          resp_data_d = '0;
          state_d     = ST_RESP;
        end else if (is_io) begin
          state_d = ST_IO;
        end else if (hit) begin
          resp_data_d = write_q ? 32'h0 : rdata;
          do_merge    = write_q;
          state_d     = ST_RESP;
        end else begin
          victim_d = victim;
          sent_d   = 1'b0;
          state_d  = dirty_q[victim][set_idx] ? ST_WBACK : ST_REFILL;
        end
      end
      ST_WBACK, ST_REFILL: begin
        memReqValid = !sent_q;
        memReqWrite = (state_q == ST_WBACK);
        drop_d      = drop_q | clearIn;
        if (memReqReady && !sent_q) sent_d = 1'b1;
        if (sent_q && memRespValid) begin
          sent_d = 1'b0;
          if (state_q == ST_WBACK) begin
            do_wb_done = 1'b1;
            state_d    = ST_REFILL;
          end else begin
            do_install = 1'b1;
            replay_d   = 1'b1;
            state_d    = (drop_q || clearIn) ? ST_IDLE : ST_LOOKUP;
          end
        end
      end
      ST_IO: begin
        ioReqValid = 1'b1;
        drop_d     = drop_q | clearIn;
        if (ioRespValid) begin
          resp_data_d = write_q ? 32'h0 : ioRespData;
          state_d     = (drop_q || clearIn) ? ST_IDLE : ST_RESP;
        end
      end
      ST_RESP: begin
        respValid = !clearIn;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign respData   = resp_data_q;
  assign respErr    = respValid & err_q;
  assign memReqAddr = (state_q == ST_WBACK) ? {tag_q[victim_q][set_idx], set_idx}
                                            : addr_q[31:BLOCK_WIDTH];
  assign memReqData = data_q[victim_q][set_idx];
  assign ioReqWrite = write_q;
  assign ioReqSize  = size_q;
  assign ioReqAddr  = addr_q;
  assign ioReqData  = wdata_q;

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      size_q      <= SIZE_NONE;
      write_q     <= 1'b0;
      replay_q    <= 1'b0;
      drop_q      <= 1'b0;
      sent_q      <= 1'b0;
      err_q       <= 1'b0;
      victim_q    <= '0;
      resp_data_q <= '0;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      write_q     <= write_d;
      replay_q    <= replay_d;
      drop_q      <= drop_d;
      sent_q      <= sent_d;
      err_q       <= err_d;
      victim_q    <= victim_d;
      resp_data_q <= resp_data_d;
      if (do_merge)   dirty_q[hit_way][set_idx]  <= 1'b1;
      if (do_wb_done) dirty_q[victim_q][set_idx] <= 1'b0;
      if (do_install) begin
        valid_q[victim_q][set_idx] <= 1'b1;
        dirty_q[victim_q][set_idx] <= 1'b0;
        rr_q[set_idx]              <= rr_next;
      end
    end
  end

  // Tag/data arrays carry no reset; writes are still blocked while in reset.
  always_ff @(posedge clkIn) begin
    if (resetIn && do_merge) data_q[hit_way][set_idx] <= merged;
    if (resetIn && do_install) begin
      data_q[victim_q][set_idx] <= memRespData;
      tag_q[victim_q][set_idx]  <= tag_idx;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        stat_hit, stat_miss, stat_wb;
  logic [31:0] hits_q, misses_q, wbacks_q;

  assign stat_hit  = (state_q == ST_LOOKUP) && !clearIn && !misaligned && !is_io && hit && !replay_q;
  assign stat_miss = (state_q == ST_LOOKUP) && !clearIn && !misaligned && !is_io && !hit;
  assign stat_wb   = stat_miss && dirty_q[victim][set_idx];

  always_ff @(posedge clkIn) begin
    if (!resetIn) begin
      hits_q   <= '0;
      misses_q <= '0;
      wbacks_q <= '0;
    end else begin
      if (stat_hit  && (hits_q   != 32'hFFFF_FFFF)) hits_q   <= hits_q + 32'd1;
      if (stat_miss && (misses_q != 32'hFFFF_FFFF)) misses_q <= misses_q + 32'd1;
      if (stat_wb   && (wbacks_q != 32'hFFFF_FFFF)) wbacks_q <= wbacks_q + 32'd1;
    end
  end

  assign statHits   = hits_q;
  assign statMisses = misses_q;
  assign statWbacks = wbacks_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_sa.sv
`default_nettype none
// ============================================================================
// tb_dcache_sa : scenario-driven self-checking bench for dcache_sa
// Revision     : 1.0
// ============================================================================
module tb_dcache_sa;

  logic         clkIn = 1'b0;
  logic         resetIn, clearIn, reqValid, reqReady, reqWrite;
  logic [1:0]   reqSize;
  logic [31:0]  reqAddr, reqData;
  logic         respValid, respErr;
  logic [31:0]  respData;
  logic         memReqValid, memReqReady, memReqWrite, memRespValid;
  logic [27:0]  memReqAddr;
  logic [127:0] memReqData, memRespData;
  logic         ioReqValid, ioReqWrite, ioRespValid;
  logic [1:0]   ioReqSize;
  logic [31:0]  ioReqAddr, ioReqData, ioRespData;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [31:0] data; logic err; } exp_t;
  typedef struct packed { logic write; logic [27:0] addr; logic [127:0] data; } mem_ev_t;
  typedef struct packed { logic write; logic [1:0] size; logic [31:0] addr; logic [31:0] data; logic stable; } io_ev_t;

  exp_t    exp_q[$];
  mem_ev_t mem_log[$];
  io_ev_t  io_log[$];
  logic [127:0] mem_store [logic [27:0]];
  logic [127:0] shadow    [logic [27:0]];

  dcache_sa dut (
    .clkIn(clkIn), .resetIn(resetIn), .clearIn(clearIn),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .reqSize(reqSize),
    .reqAddr(reqAddr), .reqData(reqData),
    .respValid(respValid), .respData(respData), .respErr(respErr),
    .memReqValid(memReqValid), .memReqReady(memReqReady), .memReqWrite(memReqWrite),
    .memReqAddr(memReqAddr), .memReqData(memReqData),
    .memRespValid(memRespValid), .memRespData(memRespData),
    .ioReqValid(ioReqValid), .ioReqWrite(ioReqWrite), .ioReqSize(ioReqSize),
    .ioReqAddr(ioReqAddr), .ioReqData(ioReqData),
    .ioRespValid(ioRespValid), .ioRespData(ioRespData)
  );

  always #5 clkIn = ~clkIn;

  function automatic logic [31:0] mem_word(input logic [27:0] la, input int w);
    return 32'h5A00_0000 | {8'h00, la[15:0], 8'h00} | 32'(w);
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_word(la, w);
    return l;
  endfunction

  function automatic logic [127:0] cur_line(input logic [27:0] la);
    if (shadow.exists(la)) return shadow[la];
    return mem_line(la);
  endfunction

  // Memory: accept one cycle after seeing a request, answer two cycles later.
  initial begin
    int rsp_wait;
    logic [127:0] rsp_line;
    memReqReady = 1'b0; memRespValid = 1'b0; memRespData = '0; rsp_wait = 0; rsp_line = '0;
    forever begin
      @(posedge clkIn); #2;
      memReqReady = 1'b0; memRespValid = 1'b0;
      if (rsp_wait > 0) begin
        rsp_wait--;
        if (rsp_wait == 0) begin memRespValid = 1'b1; memRespData = rsp_line; end
      end else if (memReqValid) begin
        memReqReady = 1'b1;
        mem_log.push_back('{memReqWrite, memReqAddr, memReqData});
        if (memReqWrite) begin
          mem_store[memReqAddr] = memReqData; rsp_line = '0;
        end else begin
          rsp_line = mem_store.exists(memReqAddr) ? mem_store[memReqAddr] : mem_line(memReqAddr);
        end
        rsp_wait = 2;
      end
    end
  end

  // MMIO: respond on the third cycle the request is seen; track field stability.
  initial begin
    int hold;
    logic stable;
    logic [1:0] sz0;
    ioRespValid = 1'b0; ioRespData = '0; hold = 0; stable = 1'b1; sz0 = '0;
    forever begin
      @(posedge clkIn); #2;
      ioRespValid = 1'b0;
      if (ioReqValid) begin
        if (hold == 0) begin sz0 = ioReqSize; stable = 1'b1; end
        else if (ioReqSize !== sz0) stable = 1'b0;
        hold++;
        if (hold == 3) begin
          ioRespValid = 1'b1; ioRespData = 32'h1234_5678;
          io_log.push_back('{ioReqWrite, ioReqSize, ioReqAddr, ioReqData, stable});
          hold = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic issue(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int guard = 0;
    while (!reqReady && guard < 100) begin @(posedge clkIn); #1; guard++; end
    reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqAddr = a; reqData = d;
    @(posedge clkIn); #1;
    reqValid = 1'b0;
  endtask

  task automatic wait_resp(input int budget, output logic got, output logic [31:0] d,
                           output logic e, output int lat);
    got = 1'b0; d = '0; e = 1'b0; lat = -1;
    for (int i = 0; i < budget; i++) begin
      if (respValid) begin got = 1'b1; d = respData; e = respErr; lat = i; break; end
      @(posedge clkIn); #1;
    end
  endtask

  task automatic test_reset();
    resetIn = 1'b0; clearIn = 1'b0; reqValid = 1'b0; reqWrite = 1'b0;
    reqSize = 2'b00; reqAddr = '0; reqData = '0;
    repeat (3) @(posedge clkIn);
    #1 resetIn = 1'b1;
    n_cmp++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL reset_reqReady: got %b expected 1", reqReady); end
    n_cmp++; if ({respValid, respErr, memReqValid, ioReqValid} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_valids: got %b expected 0000", {respValid, respErr, memReqValid, ioReqValid}); end
    n_cmp++; if (respData !== 32'h0) begin n_bad++; $display("FAIL reset_respData: got %h expected 0", respData); end
  endtask

  task automatic test_cold_load();
    logic got, e; logic [31:0] d; int lat; exp_t x;
    mem_log.delete();
    exp_q.push_back('{mem_word(28'h100, 1), 1'b0});
    issue(1'b0, 2'b11, 32'h0000_1004, 32'h0);
    wait_resp(60, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || e !== x.err) begin
      n_bad++; $display("FAIL cold_load: got v=%b d=%h e=%b expected d=%h e=%b", got, d, e, x.data, x.err); end
    n_cmp++; if (mem_log.size() != 1 || mem_log[0].write !== 1'b0 || mem_log[0].addr !== 28'h100) begin
      n_bad++; $display("FAIL cold_refill_req: got %0d events expected one refill of 0x100", mem_log.size()); end
    mem_log.delete();
    exp_q.push_back('{mem_word(28'h100, 1), 1'b0});
    issue(1'b0, 2'b11, 32'h0000_1004, 32'h0);
    wait_resp(10, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || lat != 1) begin
      n_bad++; $display("FAIL warm_hit: got v=%b d=%h lat=%0d expected d=%h lat=1", got, d, lat, x.data); end
    n_cmp++; if (mem_log.size() != 0) begin n_bad++; $display("FAIL warm_hit_traffic: got %0d mem events expected 0", mem_log.size()); end
  endtask

  task automatic test_store_byte();
    logic got, e; logic [31:0] d; int lat; exp_t x; logic [127:0] l;
    l = cur_line(28'h100); l[6*8 +: 8] = 8'hAB; shadow[28'h100] = l;
    exp_q.push_back('{32'h0, 1'b0});
    issue(1'b1, 2'b01, 32'h0000_1006, 32'h0000_00AB);
    wait_resp(10, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || e !== x.err || lat != 1) begin
      n_bad++; $display("FAIL store_byte: got v=%b d=%h e=%b lat=%0d expected d=%h lat=1", got, d, e, lat, x.data); end
    exp_q.push_back('{l[32 +: 32], 1'b0});
    issue(1'b0, 2'b11, 32'h0000_1004, 32'h0);
    wait_resp(10, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data) begin
      n_bad++; $display("FAIL store_readback: got v=%b d=%h expected %h", got, d, x.data); end
  endtask

  task automatic test_evict();
    logic got, e; logic [31:0] d; int lat; exp_t x;
    mem_log.delete();
    exp_q.push_back('{mem_word(28'h140, 0), 1'b0});
    issue(1'b0, 2'b11, 32'h0000_1400, 32'h0);
    wait_resp(60, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || mem_log.size() != 1) begin
      n_bad++; $display("FAIL fill_way1: got v=%b d=%h events=%0d expected d=%h events=1", got, d, mem_log.size(), x.data); end
    mem_log.delete();
    exp_q.push_back('{mem_word(28'h180, 0), 1'b0});
    issue(1'b0, 2'b11, 32'h0000_1800, 32'h0);
    wait_resp(80, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data) begin
      n_bad++; $display("FAIL evict_load: got v=%b d=%h expected %h", got, d, x.data); end
    n_cmp++; if (mem_log.size() != 2) begin
      n_bad++; $display("FAIL evict_events: got %0d expected 2", mem_log.size());
    end else begin
      if (mem_log[0].write !== 1'b1 || mem_log[0].addr !== 28'h100 || mem_log[0].data !== shadow[28'h100]) begin
        n_bad++; $display("FAIL wback: got w=%b a=%h d=%h expected w=1 a=100 d=%h",
                          mem_log[0].write, mem_log[0].addr, mem_log[0].data, shadow[28'h100]); end
      n_cmp++;
      if (mem_log[1].write !== 1'b0 || mem_log[1].addr !== 28'h180) begin
        n_bad++; $display("FAIL refill_after_wback: got w=%b a=%h expected w=0 a=180", mem_log[1].write, mem_log[1].addr); end
    end
  endtask

  task automatic test_misaligned();
    logic got, e; logic [31:0] d; int lat; exp_t x; int io_n;
    mem_log.delete(); io_n = io_log.size();
    exp_q.push_back('{32'h0, 1'b1});
    issue(1'b0, 2'b10, 32'h0000_1001, 32'h0);
    wait_resp(10, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || e !== x.err || lat != 1) begin
      n_bad++; $display("FAIL misaligned_err: got v=%b e=%b lat=%0d expected e=1 lat=1", got, e, lat); end
    n_cmp++; if (mem_log.size() != 0 || io_log.size() != io_n) begin
      n_bad++; $display("FAIL misaligned_traffic: got mem=%0d io=%0d expected none", mem_log.size(), io_log.size() - io_n); end
    exp_q.push_back('{mem_word(28'h180, 0), 1'b0});
    issue(1'b0, 2'b11, 32'h0000_1800, 32'h0);
    wait_resp(10, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || e !== 1'b0 || lat != 1) begin
      n_bad++; $display("FAIL after_misaligned_hit: got v=%b d=%h e=%b lat=%0d expected d=%h lat=1", got, d, e, lat, x.data); end
  endtask

  task automatic test_io();
    logic got, e; logic [31:0] d; int lat; exp_t x;
    mem_log.delete(); io_log.delete();
    exp_q.push_back('{32'h0, 1'b0});
    issue(1'b1, 2'b11, 32'h0003_0000, 32'h0000_0041);
    wait_resp(20, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || e !== x.err) begin
      n_bad++; $display("FAIL io_store_resp: got v=%b d=%h e=%b expected d=0 e=0", got, d, e); end
    n_cmp++; if (io_log.size() != 1 || io_log[0] !== '{1'b1, 2'b11, 32'h0003_0000, 32'h0000_0041, 1'b1}) begin
      n_bad++; $display("FAIL io_store_req: got n=%0d ev=%h expected one word store of 41 to 30000", io_log.size(),
                        (io_log.size() > 0) ? io_log[0] : '0); end
    exp_q.push_back('{32'h1234_5678, 1'b0});
    issue(1'b0, 2'b11, 32'h0003_0000, 32'h0);
    wait_resp(20, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || io_log.size() != 2) begin
      n_bad++; $display("FAIL io_load: got v=%b d=%h io=%0d expected d=%h io=2", got, d, io_log.size(), x.data); end
    n_cmp++; if (mem_log.size() != 0) begin n_bad++; $display("FAIL io_alloc: got %0d mem events expected 0", mem_log.size()); end
  endtask

  task automatic test_clear_refill();
    logic got, e; logic [31:0] d; int lat; exp_t x; int guard; logic seen_resp;
    mem_log.delete(); seen_resp = 1'b0;
    issue(1'b0, 2'b11, 32'h0000_2010, 32'h0);
    guard = 0;
    while (mem_log.size() == 0 && guard < 40) begin
      if (respValid) seen_resp = 1'b1;
      @(posedge clkIn); #1; guard++;
    end
    clearIn = 1'b1;
    @(posedge clkIn); #1;
    clearIn = 1'b0;
    guard = 0;
    while (!reqReady && guard < 40) begin
      if (respValid) seen_resp = 1'b1;
      @(posedge clkIn); #1; guard++;
    end
    repeat (3) begin if (respValid) seen_resp = 1'b1; @(posedge clkIn); #1; end
    n_cmp++; if (seen_resp || !reqReady || exp_q.size() != 0) begin
      n_bad++; $display("FAIL clear_refill: got resp=%b ready=%b expected resp=0 ready=1", seen_resp, reqReady); end
    exp_q.push_back('{mem_word(28'h201, 0), 1'b0});
    issue(1'b0, 2'b11, 32'h0000_2010, 32'h0);
    wait_resp(10, got, d, e, lat);
    x = exp_q.pop_front();
    n_cmp++; if (!got || d !== x.data || lat != 1 || mem_log.size() != 1) begin
      n_bad++; $display("FAIL clear_then_hit: got v=%b d=%h lat=%0d mem=%0d expected d=%h lat=1 mem=1",
                        got, d, lat, mem_log.size(), x.data); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_byte();
    test_evict();
    test_misaligned();
    test_io();
    test_clear_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
